// File: rtl/clk3_bcd_counter.sv
// clk3_bcd_counter: synchronizes the divided clk3 square wave into the clk50
// domain and counts its rising edges on a NUM_DIGITS-digit BCD counter that
// drives active-low 7-segment displays. Each accepted clk3 rise also produces
// a one-cycle tick strobe. run gates counting; clear forces the count to zero.
// Optional feature macro: CLK3_BCD_DOWN_EN adds a 'down' input that makes the
// counter decrement (0 rolls to 9 with borrow).
module clk3_bcd_counter #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk50,
    input  logic                      rst_n,
    input  logic                      clk3,
    input  logic                      run,
    input  logic                      clear,
`ifdef CLK3_BCD_DOWN_EN
    input  logic                      down,
`endif
    output logic                      tick,
    output logic                      wrap,
    output logic                      running,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic [7*NUM_DIGITS-1:0]   hex_n
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0]  clk3_sync_q;
    logic [SYNC_STAGES-1:0]  run_sync_q;
    logic [SYNC_STAGES-1:0]  clear_sync_q;
`ifdef CLK3_BCD_DOWN_EN
    logic [SYNC_STAGES-1:0]  down_sync_q;
`endif
    logic [SYNC_STAGES:0]    fill_q;
    logic                    clk3_dly_q;

    logic                    clk3_s;
    logic                    run_s;
    logic                    clear_s;
    logic                    down_s;
    logic                    primed;
    logic                    rise;

    state_e                  state_q, state_d;
    logic                    tick_q;
    logic                    wrap_q, wrap_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign clk3_s  = clk3_sync_q[SYNC_STAGES-1];
    assign run_s   = run_sync_q[SYNC_STAGES-1];
    assign clear_s = clear_sync_q[SYNC_STAGES-1];
`ifdef CLK3_BCD_DOWN_EN
    assign down_s  = down_sync_q[SYNC_STAGES-1];
`else
    assign down_s  = 1'b0;
`endif

    // The edge detector is only trusted once the synchronizer and clk3_dly_q
    // hold real samples, so a clk3 already high at reset release is not
    // mistaken for a rising edge.
    assign primed = fill_q[SYNC_STAGES];
    assign rise   = clk3_s & ~clk3_dly_q & primed;

    // Synchronizer chains, post-reset fill tracker and edge-detect delay flop.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            clk3_sync_q  <= '0;
            run_sync_q   <= '0;
            clear_sync_q <= '0;
`ifdef CLK3_BCD_DOWN_EN
            down_sync_q  <= '0;
`endif
            fill_q       <= '0;
            clk3_dly_q   <= 1'b0;
        end else begin
            clk3_sync_q  <= {clk3_sync_q[SYNC_STAGES-2:0], clk3};
            run_sync_q   <= {run_sync_q[SYNC_STAGES-2:0], run};
            clear_sync_q <= {clear_sync_q[SYNC_STAGES-2:0], clear};
`ifdef CLK3_BCD_DOWN_EN
            down_sync_q  <= {down_sync_q[SYNC_STAGES-2:0], down};
`endif
            fill_q       <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            clk3_dly_q   <= clk3_s;
        end
    end

    // Run/stop FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (run_s)  state_d = ST_RUN;
            ST_RUN:  if (!run_s) state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    // Count next state: clear wins, then a tick while in RUN steps the counter.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        logic [3:0] nd;
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        carry  = 1'b1;
        digit  = '0;
        nd     = '0;
        if (clear_s) begin
            bcd_d = '0;
        end else if (rise && (state_q == ST_RUN)) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit = bcd_q[4*i +: 4];
                nd    = digit;
                if (carry) begin
                    if (down_s) begin
                        if (digit == 4'd0) begin
                            nd    = 4'd9;
                            carry = 1'b1;
                        end else if (digit > 4'd9) begin
                            nd    = 4'd8;
                            carry = 1'b0;
                        end else begin
                            nd    = digit - 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (digit >= 4'd9) begin
                            nd    = 4'd0;
                            carry = 1'b1;
                        end else begin
                            nd    = digit + 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
                bcd_d[4*i +: 4] = nd;
            end
            wrap_d = carry;
        end
    end

    // Segment patterns follow the next-state count so they update with bcd.
    always_comb begin
        hex_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            hex_d[7*i +: 7] = seg7(bcd_d[4*i +: 4]);
        end
    end

    // Output and state registers.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            bcd_q   <= '0;
            hex_q   <= {NUM_DIGITS{7'h40}};
        end else begin
            state_q <= state_d;
            tick_q  <= rise;
            wrap_q  <= wrap_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
        end
    end

    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign running = (state_q == ST_RUN);
    assign bcd     = bcd_q;
    assign hex_n   = hex_q;

endmodule
